// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: program-load, start and instruction-issue signals of instr_fetch_unit.
// master = fetch unit side, slave = host / execute-stage side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [31:0]       ir;
    logic              ir_valid;
    logic              ir_ready;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport master (
        input  start, load_we, load_addr, load_data, ir_ready,
        output ir, ir_valid, pc, busy, halted
    );

    modport slave (
        output start, load_we, load_addr, load_data, ir_ready,
        input  ir, ir_valid, pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program memory, PC and IR sequencer issuing one instruction at a time over valid/ready.
// Define IFU_EXEC_DELAY_EN to insert an IFU_EXEC_DELAY-cycle settling wait after every accept.
module instr_fetch_unit #(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned ADDR_W     = $clog2(PROG_DEPTH),
    parameter logic [4:0]  HALT_OP    = 5'b11111
) (
    input  logic               clk,
    input  logic               sys_rst,
    instr_fetch_unit_if.master bus
);

`ifdef IFU_EXEC_DELAY_EN
    localparam int unsigned IFU_EXEC_DELAY = 4;
    localparam int unsigned CNT_W = (IFU_EXEC_DELAY > 1) ? $clog2(IFU_EXEC_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_NEXT, S_HALTED, S_DELAY
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_NEXT, S_HALTED
    } state_t;
`endif

    logic [31:0]       mem_q [PROG_DEPTH];
    logic [31:0]       rdata_q;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              mem_we;
    logic              idle_like;
    logic              accept;
`ifdef IFU_EXEC_DELAY_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign mem_we    = bus.load_we && idle_like;
    assign accept    = (state_q == S_ISSUE) && bus.ir_ready;

    // Program store: writes only while idle/halted, registered read issued from FETCH.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
        if (state_q == S_FETCH) begin
            rdata_q <= mem_q[pc_q];
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
`ifdef IFU_EXEC_DELAY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef IFU_EXEC_DELAY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef IFU_EXEC_DELAY_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                ir_d    = rdata_q;
                state_d = (rdata_q[31:27] == HALT_OP) ? S_HALTED : S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
`ifdef IFU_EXEC_DELAY_EN
                    state_d = S_DELAY;
                    cnt_d   = CNT_W'(IFU_EXEC_DELAY - 1);
`else
                    state_d = S_NEXT;
`endif
                end
            end
`ifdef IFU_EXEC_DELAY_EN
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            // PROG_DEPTH is a power of two, so the natural overflow wraps to address 0.
            S_NEXT: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ir       = ir_q;
    assign bus.pc       = pc_q;
    assign bus.ir_valid = (state_q == S_ISSUE);
    assign bus.busy     = !idle_like;
    assign bus.halted   = (state_q == S_HALTED);

endmodule
